// File: rtl/freq_generator.sv
// Programmable square-wave source driven by a fractional phase accumulator.
// Rate changes land on rising edges of out; a stop never truncates a high phase.
module freq_generator #(
  parameter int CLK_HZ = 100000000,
  parameter int ACC_W  = 34
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] freq_in,
  output logic        out,
  output logic        tick,
  output logic [31:0] freq_act,
  output logic        err
);

  localparam logic [ACC_W-1:0] MOD  = ACC_W'(CLK_HZ);
  localparam logic [31:0]      HALF = 32'(CLK_HZ / 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [ACC_W-1:0] step_sum;
  logic [31:0]      pend, pend_next;
  logic             pend_v, pend_v_next;
  logic [31:0]      freq_next;
  logic             out_next, tick_next, err_next;
  logic             wrap, stop_req;

  // The accumulator wraps at CLK_HZ; each wrap is one half-period of out.
  assign step_sum = acc + ACC_W'({freq_act, 1'b0});
  assign wrap     = (step_sum >= MOD);
  assign stop_req = !en || (pend_v && (pend == 32'd0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (en && !pend_v && (freq_act != 32'd0)) state_next = RUN;
      RUN: begin
        if (stop_req && (!out || wrap)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_next    = acc;
    out_next    = out;
    tick_next   = 1'b0;
    freq_next   = freq_act;
    pend_next   = pend;
    pend_v_next = pend_v;
    err_next    = err;
    case (state)
      IDLE: begin
        acc_next = '0;
        out_next = 1'b0;
        if (pend_v) begin
          freq_next   = pend;
          pend_v_next = 1'b0;
        end
      end
      RUN: begin
        if (!out && stop_req) begin
          acc_next = '0;
          out_next = 1'b0;
        end else if (wrap) begin
          acc_next = step_sum - MOD;
          out_next = !out;
          if (!out) begin
            tick_next = 1'b1;
            // A pending rate starts a fresh half-period from a clean accumulator.
            if (pend_v && (pend != 32'd0)) begin
              freq_next   = pend;
              pend_v_next = 1'b0;
              acc_next    = '0;
            end
          end else if (stop_req) begin
            acc_next = '0;
          end
        end else begin
          acc_next = step_sum;
        end
      end
      default: begin
        acc_next = '0;
        out_next = 1'b0;
      end
    endcase
    // A capture always wins, so a load on an applying edge waits for the next one.
    if (load) begin
      pend_v_next = 1'b1;
      if (freq_in > HALF) begin
        pend_next = HALF;
        err_next  = 1'b1;
      end else begin
        pend_next = freq_in;
        err_next  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      out      <= 1'b0;
      tick     <= 1'b0;
      freq_act <= 32'd0;
      pend     <= 32'd0;
      pend_v   <= 1'b0;
      err      <= 1'b0;
    end else begin
      acc      <= acc_next;
      out      <= out_next;
      tick     <= tick_next;
      freq_act <= freq_next;
      pend     <= pend_next;
      pend_v   <= pend_v_next;
      err      <= err_next;
    end
  end

endmodule

// File: tb/tb_freq_generator.sv
// Directed bench for freq_generator with CLK_HZ=1000 so periods are easy to hand-count.
module tb_freq_generator;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [31:0] freq_in;
  logic        out;
  logic        tick;
  logic [31:0] freq_act;
  logic        err;

  int checks = 0;
  int errors = 0;

  freq_generator #(.CLK_HZ(1000), .ACC_W(34)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .freq_in(freq_in),
    .out(out), .tick(tick), .freq_act(freq_act), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the number of edges until out equals v, or -1 when the budget runs out.
  task automatic wait_out(input logic v, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (out === v) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    en = 1'b0; load = 1'b0; freq_in = 32'd0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Load a rate with enable high and stop one edge after the capture edge.
  task automatic start_rate(input logic [31:0] f);
    load = 1'b1; freq_in = f; en = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
  endtask

  task automatic test_reset();
    en = 1'b0; load = 1'b0; freq_in = 32'd0; rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL reset_out got %b want 0", out); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
    checks++; if (freq_act !== 32'd0) begin errors++; $display("FAIL reset_freq got %0d want 0", freq_act); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    load = 1'b1; freq_in = 32'd50; en = 1'b1;
    step(1);
    load = 1'b0;
    checks++; if (freq_act !== 32'd0) begin errors++; $display("FAIL basic_freq_early got %0d want 0", freq_act); end
    step(1);
    checks++; if (freq_act !== 32'd50) begin errors++; $display("FAIL basic_freq got %0d want 50", freq_act); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", err); end
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL basic_idle_out got %b want 0", out); end
    wait_out(1'b1, 40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL basic_first_rise got %0d want 11", n); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL basic_tick got %b want 1", tick); end
    step(1);
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL basic_tick_pulse got %b want 0", tick); end
    wait_out(1'b0, 40, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL basic_fall got %0d want 9", n); end
    wait_out(1'b1, 40, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL basic_period got %0d want 10", n); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL basic_tick2 got %b want 1", tick); end
  endtask

  task automatic test_fractional();
    int n;
    int ticks;
    do_reset();
    start_rate(32'd300);
    checks++; if (freq_act !== 32'd300) begin errors++; $display("FAIL frac_freq got %0d want 300", freq_act); end
    wait_out(1'b1, 20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL frac_first_rise got %0d want 3", n); end
    wait_out(1'b0, 20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL frac_int_a got %0d want 2", n); end
    wait_out(1'b1, 20, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL frac_int_b got %0d want 1", n); end
    wait_out(1'b0, 20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL frac_int_c got %0d want 2", n); end
    ticks = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1);
      if (tick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 300) begin errors++; $display("FAIL frac_tick_count got %0d want 300", ticks); end
  endtask

  task automatic test_clamp();
    int n;
    do_reset();
    start_rate(32'd600);
    checks++; if (freq_act !== 32'd500) begin errors++; $display("FAIL clamp_freq got %0d want 500", freq_act); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL clamp_err got %b want 1", err); end
    wait_out(1'b1, 10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL clamp_first_rise got %0d want 2", n); end
    step(1);
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL clamp_toggle_lo got %b want 0", out); end
    step(1);
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL clamp_toggle_hi got %b want 1", out); end
    load = 1'b1; freq_in = 32'd100;
    step(1);
    load = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clamp_err_clear got %b want 0", err); end
    checks++; if (freq_act !== 32'd500) begin errors++; $display("FAIL clamp_hold_freq got %0d want 500", freq_act); end
    step(1);
    checks++; if (freq_act !== 32'd100) begin errors++; $display("FAIL clamp_apply got %0d want 100", freq_act); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL clamp_apply_tick got %b want 1", tick); end
    wait_out(1'b0, 20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL clamp_new_half got %0d want 5", n); end
  endtask

  task automatic test_stop_high();
    int n;
    int highs;
    do_reset();
    start_rate(32'd50);
    wait_out(1'b1, 40, n);
    step(3);
    en = 1'b0;
    wait_out(1'b0, 20, n);
    checks++; if (n !== 7) begin errors++; $display("FAIL stop_high_fall got %0d want 7", n); end
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (out !== 1'b0) highs++;
    end
    checks++; if (highs !== 0) begin errors++; $display("FAIL stop_high_idle got %0d want 0", highs); end
    checks++; if (freq_act !== 32'd50) begin errors++; $display("FAIL stop_high_freq got %0d want 50", freq_act); end
  endtask

  task automatic test_stop_low();
    int n;
    do_reset();
    start_rate(32'd50);
    wait_out(1'b1, 40, n);
    wait_out(1'b0, 40, n);
    step(3);
    en = 1'b0;
    step(1);
    en = 1'b1;
    wait_out(1'b1, 40, n);
    checks++; if (n !== 11) begin errors++; $display("FAIL stop_low_restart got %0d want 11", n); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    start_rate(32'd50);
    wait_out(1'b1, 40, n);
    step(3);
    load = 1'b1; freq_in = 32'd100;
    step(1);
    freq_in = 32'd200;
    step(1);
    load = 1'b0;
    wait_out(1'b0, 20, n);
    checks++; if (n !== 5) begin errors++; $display("FAIL b2b_fall got %0d want 5", n); end
    checks++; if (freq_act !== 32'd50) begin errors++; $display("FAIL b2b_hold got %0d want 50", freq_act); end
    wait_out(1'b1, 20, n);
    checks++; if (n !== 10) begin errors++; $display("FAIL b2b_rise got %0d want 10", n); end
    checks++; if (freq_act !== 32'd200) begin errors++; $display("FAIL b2b_apply got %0d want 200", freq_act); end
    wait_out(1'b0, 10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_int_a got %0d want 3", n); end
    wait_out(1'b1, 10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_int_b got %0d want 2", n); end
    wait_out(1'b0, 10, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_int_c got %0d want 3", n); end
    wait_out(1'b1, 10, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL b2b_int_d got %0d want 2", n); end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    start_rate(32'd50);
    wait_out(1'b1, 40, n);
    step(3);
    load = 1'b1; freq_in = 32'd600;
    step(1);
    load = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL areset_pre_err got %b want 1", err); end
    checks++; if (out !== 1'b1) begin errors++; $display("FAIL areset_pre_out got %b want 1", out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out !== 1'b0) begin errors++; $display("FAIL areset_out got %b want 0", out); end
    checks++; if (freq_act !== 32'd0) begin errors++; $display("FAIL areset_freq got %0d want 0", freq_act); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL areset_err got %b want 0", err); end
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; load = 1'b0; freq_in = 32'd0;
    test_reset();
    test_basic();
    test_fractional();
    test_clamp();
    test_stop_high();
    test_stop_low();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_generator.md
Name: freq_generator

Overview:
- Programmable square-wave source: takes a frequency in Hz and drives a 50%-duty-average square wave at that frequency.
- It is the stimulus-side counterpart of freq_counter. Its OUT drives freq_counter.IN in loopback, and FREQ_ACT can feed disp_controller.
- Uses a fractional accumulator, so the average output frequency is exact in integer Hz.
- Frequency changes take effect glitch-free on rising edges of OUT.

Parameters:
- CLK_HZ, 100000000: CLK frequency in Hz. It is also the accumulator modulus.
- ACC_W, 34: accumulator width. Must satisfy 2^ACC_W > 2*CLK_HZ.

Ports:
- CLK, input, 1: system clock, rising edge.
- RST_N, input, 1: asynchronous active-low reset.
- EN, input, 1: run enable.
- LOAD, input, 1: one-cycle strobe that captures FREQ_IN.
- FREQ_IN, input, 32: requested frequency in Hz.
- OUT, output, 1: generated square wave, registered.
- TICK, output, 1: one-cycle pulse on each cycle where OUT goes 0->1.
- FREQ_ACT, output, 32: frequency currently applied, after clamping.
- ERR, output, 1: the last load was out of range and was clamped.

Behaviour:
- Reset (asynchronous, takes effect immediately mid-operation):
  - OUT=0, TICK=0, FREQ_ACT=0, ERR=0.
  - acc=0, pend=0, pend_v=0, state=IDLE.
- Capture (any state), when LOAD=1:
  - If FREQ_IN > CLK_HZ/2: pend <= CLK_HZ/2 and ERR <= 1.
  - Otherwise: pend <= FREQ_IN and ERR <= 0.
  - In both cases pend_v <= 1.
  - If several LOADs arrive before the value is applied, the last one wins.
- State IDLE:
  - OUT=0 and acc=0.
  - If pend_v: FREQ_ACT <= pend and pend_v <= 0.
  - Go to RUN when EN=1, FREQ_ACT != 0 and pend_v=0. acc=0 on entry.
  - Timing: LOAD in cycle N gives FREQ_ACT in N+1 and RUN in N+2.
- State RUN, every cycle:
  - s = acc + 2*FREQ_ACT.
  - If s >= CLK_HZ: acc <= s - CLK_HZ and OUT toggles.
  - Otherwise: acc <= s.
  - Average half-period is CLK_HZ/(2*FREQ_ACT) cycles. The first toggle (0->1) comes ceil(CLK_HZ/(2*FREQ_ACT)) cycles after entering RUN.
- Rising toggle (OUT 0->1):
  - TICK=1 in the same cycle OUT becomes 1.
  - If pend_v and pend != 0: FREQ_ACT <= pend, pend_v <= 0, and acc <= 0, discarding the remainder.
  - The new rate governs the next half-period.
- Stop:
  - A stop is requested when EN=0 or when pend_v holds a 0.
  - If OUT=0 when the stop is seen, go to IDLE next cycle.
  - If OUT=1, keep running until the next falling toggle, then go to IDLE in that same cycle (OUT=0). The high phase is never truncated.
  - A zero pend is applied in IDLE.
- Boundaries:
  - FREQ_ACT = CLK_HZ/2: OUT toggles every cycle (period 2 cycles).
  - FREQ_IN = 0 while in IDLE: stays in IDLE, OUT=0.
  - LOAD in the same cycle as a rising toggle: the value is captured, not applied at that edge, and applied at the following rising edge.
  - EN deasserted and LOAD in the same cycle: the capture happens, the stop proceeds, and IDLE then applies the value.
- Arithmetic:
  - All comparisons are unsigned, ACC_W bits wide.
  - The clamp guarantees 2*FREQ_ACT <= CLK_HZ, so acc < CLK_HZ always and at most one toggle happens per cycle.

Test Plan:
- CLK_HZ=1000, LOAD FREQ_IN=50, EN=1:
  - FREQ_ACT=50 one cycle after LOAD; RUN entered one cycle after that.
  - OUT toggles every 10 cycles (period 20); first rise 10 cycles after RUN entry; TICK once per 20 cycles.
- CLK_HZ=1000, FREQ_IN=300:
  - Toggle intervals repeat 2,2,1.
  - Exactly 300 rising TICKs in 1000 cycles.
- CLK_HZ=1000, FREQ_IN=600:
  - FREQ_ACT=500, ERR=1, OUT toggles every cycle.
  - A later LOAD of 100 clears ERR and applies at the next rising OUT.
- CLK_HZ=1000, running at 50:
  - EN dropped 3 cycles after a rising OUT: OUT stays 1 until its scheduled fall (7 cycles later), then IDLE with OUT=0.
  - EN dropped while OUT=0: IDLE next cycle.
- CLK_HZ=1000:
  - LOAD 100 then LOAD 200 mid-period: first rising edge after the loads keeps period 20; after it FREQ_ACT=200 and OUT toggles every 2.5 cycles on average (intervals 3,2).
  - RST_N pulsed low mid-high-phase: OUT=0, FREQ_ACT=0, ERR=0 immediately, without waiting for CLK.
- Default CLK_HZ, loopback OUT to freq_counter.IN, FREQ_IN=50, EN=1: freq output settles to 50 after two counter gate periods.
